// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch stage and the IF/ID pipeline register.
// Contents:
//   RESET_PC_DEFAULT / NOP_INST_DEFAULT  default parameter values
//   fetch_state_t                        fetch FSM encoding (FETCH=0, HELD=1)
//   if_id_t                              IF/ID register fields
//   word_align()                         clears the two low address bits
package if_id_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;   // sll $0,$0,0

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc4;
        logic              valid;
    } if_id_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-word skid buffer for the fetch stage. Captures the instruction word that
// returned while the pipeline was stalled so it is not fetched a second time.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        capture din and mark full
//   clear       drop the stored word (wins over load)
//   din         word to capture
//   dout        stored word
//   full        a word is stored
module if_skid_buf
    import if_id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [INST_W-1:0] din,
    output logic [INST_W-1:0] dout,
    output logic              full
);

    logic [INST_W-1:0] word_reg;
    logic              full_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg <= '0;
            full_reg <= 1'b0;
        end else if (clear) begin
            full_reg <= 1'b0;
        end else if (load) begin
            word_reg <= din;
            full_reg <= 1'b1;
        end
    end

    assign dout = word_reg;
    assign full = full_reg;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
// Owns the PC, issues one instruction fetch per cycle and latches the returned
// word into IF/ID. Honours stall (_stall_en=0) and ID-resolved branch redirects.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   _stall_en      0 = hold PC and IF/ID this cycle
//   branch_taken   redirect PC to branch_target and flush IF/ID
//   branch_target  redirect address (low two bits ignored)
//   imem_req       fetch request (registered state only, no path from stall/branch)
//   imem_addr      fetch address (= PC)
//   imem_ready     imem_rdata valid this cycle for imem_addr
//   imem_rdata     fetched instruction
//   if_id_inst     instruction presented to ID
//   if_id_pc4      PC+4 of if_id_inst
//   if_id_valid    if_id_inst is a real instruction (0 = NOP bubble)
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        _stall_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    fetch_state_t      state_reg;
    logic [PC_W-1:0]   pc_reg;
    logic [PC_W-1:0]   pc_plus4;
    if_id_t            if_id_reg;

    logic              skid_load;
    logic              skid_clear;
    logic [INST_W-1:0] skid_word;
    logic              skid_full;

    // Wraps naturally at 2^32.
    assign pc_plus4 = pc_reg + 32'd4;

    // A word returned during a stall is parked; any unstalled cycle either
    // consumes it (HELD) or discards it (branch), so clearing on _stall_en is enough.
    assign skid_load  = !_stall_en && (state_reg == FETCH) && imem_ready;
    assign skid_clear = _stall_en;

    if_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .din   (imem_rdata),
        .dout  (skid_word),
        .full  (skid_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= RESET_PC;
            state_reg <= FETCH;
            if_id_reg <= '{inst: NOP_INST, pc4: '0, valid: 1'b0};
        end else if (!_stall_en) begin
            // Branch is ignored here: ID holds it and re-presents it after the stall.
            if ((state_reg == FETCH) && imem_ready) begin
                state_reg <= HELD;
            end
        end else if (branch_taken) begin
            pc_reg          <= word_align(branch_target);
            if_id_reg.inst  <= NOP_INST;
            if_id_reg.valid <= 1'b0;
            state_reg       <= FETCH;
        end else if (state_reg == HELD) begin
            if_id_reg <= '{inst: skid_word, pc4: pc_plus4, valid: skid_full};
            pc_reg    <= pc_plus4;
            state_reg <= FETCH;
        end else if (imem_ready) begin
            if_id_reg <= '{inst: imem_rdata, pc4: pc_plus4, valid: 1'b1};
            pc_reg    <= pc_plus4;
        end else begin
            // Memory not ready: bubble, pc4 keeps its last value.
            if_id_reg.inst  <= NOP_INST;
            if_id_reg.valid <= 1'b0;
        end
    end

    assign imem_req    = rst_n && (state_reg == FETCH);
    assign imem_addr   = pc_reg;
    assign if_id_inst  = if_id_reg.inst;
    assign if_id_pc4   = if_id_reg.pc4;
    assign if_id_valid = if_id_reg.valid;

endmodule
